// File: rtl/stage_4.sv
// stage_4: increment stage with a 2-entry skid buffer.
// Adds 1 (mod 2^DATA_W) to each incoming beat and hands it downstream
// through an output register backed by a skid register, so that one
// in-flight beat can be absorbed when the next stage stalls. The stall
// returned upstream is registered. Drop and beat counters are exposed
// for observation.
module stage_4 #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_stall,
    input  logic              i_stall,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic [CNT_W-1:0]  o_beat_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] data_inc;
    logic              accept;
    logic              deliver;
    logic              drop;

    // Handshake qualifiers. Flush overrides both accept and drop.
    assign data_inc = i_data + DATA_W'(1);
    assign accept   = i_valid && !o_stall && !i_flush;
    assign deliver  = o_valid && !i_stall;
    assign drop     = i_valid &&  o_stall && !i_flush;

    assign o_data = out_q;

    // Occupancy FSM with registered o_valid/o_stall and the two data registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            o_valid <= 1'b0;
            o_stall <= 1'b0;
            // NOTE: the data registers are reset too, so o_data reads 0 out of reset.
            out_q   <= '0;
            skid_q  <= '0;
        end else if (i_flush) begin
            // Contents are abandoned, not cleared: out_q/skid_q keep their values.
            state_q <= EMPTY;
            o_valid <= 1'b0;
            o_stall <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block reading the pre-edge values, independent of statement order.
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_q   <= data_inc;
                        state_q <= ONE;
                        o_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        out_q <= data_inc;
                    end else if (accept && !deliver) begin
                        skid_q  <= data_inc;
                        state_q <= TWO;
                        o_stall <= 1'b1;
                    end else if (!accept && deliver) begin
                        state_q <= EMPTY;
                        o_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        out_q   <= skid_q;
                        state_q <= ONE;
                        o_stall <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    o_valid <= 1'b0;
                    o_stall <= 1'b0;
                end
            endcase
        end
    end

    // Saturating drop counter and wrapping delivered-beat counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop_cnt <= '0;
            o_beat_cnt <= '0;
        end else begin
            if (drop && (o_drop_cnt != CNT_MAX)) begin
                o_drop_cnt <= o_drop_cnt + CNT_W'(1);
            end
            if (deliver && !i_flush) begin
                o_beat_cnt <= o_beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stage_4.sv
// Directed testbench for stage_4. Inputs change 1 time unit after the
// rising edge; outputs are checked at the same point, so every check sees
// the state produced by the edge just taken.
module tb_stage_4;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_flush;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_stall;
    logic              i_stall;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic [CNT_W-1:0]  o_drop_cnt;
    logic [CNT_W-1:0]  o_beat_cnt;

    int total = 0;
    int bad   = 0;

    stage_4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (i_flush),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_stall    (o_stall),
        .i_stall    (i_stall),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_drop_cnt (o_drop_cnt),
        .o_beat_cnt (o_beat_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic s, input logic f);
        i_valid = v;
        i_data  = d;
        i_stall = s;
        i_flush = f;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #22;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", o_stall); end
        total++; if (o_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", o_data); end
        total++; if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", o_drop_cnt); end
        total++; if (o_beat_cnt !== 8'd0) begin bad++; $display("FAIL reset_beat got=%0d exp=0", o_beat_cnt); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
            step();
            total++;
            if (o_valid !== 1'b1 || o_data !== DATA_W'(i + 1) || o_stall !== 1'b0) begin
                bad++;
                $display("FAIL stream_%0d got v=%0b d=%h s=%0b exp v=1 d=%h s=0", i, o_valid, o_data, o_stall, DATA_W'(i + 1));
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%0b exp=0", o_valid); end
        total++; if (o_beat_cnt !== 8'd10) begin bad++; $display("FAIL stream_beats got=%0d exp=10", o_beat_cnt); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        step();
        total++; if (o_valid !== 1'b1 || o_data !== 16'h0000) begin bad++; $display("FAIL wrap_data got v=%0b d=%h exp v=1 d=0000", o_valid, o_data); end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL wrap_one_cycle got=%0b exp=0", o_valid); end
        total++; if (o_beat_cnt !== 8'd11) begin bad++; $display("FAIL wrap_beats got=%0d exp=11", o_beat_cnt); end
    endtask

    task automatic test_stall();
        drive(1'b1, 16'h0010, 1'b0, 1'b0);
        step();
        total++; if (o_data !== 16'h0011 || o_stall !== 1'b0) begin bad++; $display("FAIL stall_first got d=%h s=%0b exp d=0011 s=0", o_data, o_stall); end
        // Downstream stalls in the same cycle 0x11 is accepted: it must go to skid.
        drive(1'b1, 16'h0011, 1'b1, 1'b0);
        step();
        total++; if (o_stall !== 1'b1 || o_data !== 16'h0011 || o_valid !== 1'b1) begin bad++; $display("FAIL stall_enter got s=%0b d=%h v=%0b exp s=1 d=0011 v=1", o_stall, o_data, o_valid); end
        drive(1'b0, 16'h0012, 1'b1, 1'b0);
        step();
        step();
        total++; if (o_stall !== 1'b1 || o_data !== 16'h0011) begin bad++; $display("FAIL stall_hold got s=%0b d=%h exp s=1 d=0011", o_stall, o_data); end
        drive(1'b0, 16'h0012, 1'b0, 1'b0);
        step();
        total++; if (o_stall !== 1'b0 || o_data !== 16'h0012 || o_valid !== 1'b1) begin bad++; $display("FAIL stall_release got s=%0b d=%h v=%0b exp s=0 d=0012 v=1", o_stall, o_data, o_valid); end
        drive(1'b1, 16'h0012, 1'b0, 1'b0);
        step();
        total++; if (o_data !== 16'h0013) begin bad++; $display("FAIL stall_order1 got=%h exp=0013", o_data); end
        drive(1'b1, 16'h0013, 1'b0, 1'b0);
        step();
        total++; if (o_data !== 16'h0014) begin bad++; $display("FAIL stall_order2 got=%h exp=0014", o_data); end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        total++; if (o_beat_cnt !== 8'd15 || o_drop_cnt !== 8'd0) begin bad++; $display("FAIL stall_counts got beats=%0d drops=%0d exp beats=15 drops=0", o_beat_cnt, o_drop_cnt); end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h0040, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0041, 1'b1, 1'b0);
        step();
        total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL flush_setup got s=%0b exp=1", o_stall); end
        // Flush with a beat on the input and a would-be deliver.
        drive(1'b1, 16'h0077, 1'b0, 1'b1);
        step();
        total++; if (o_valid !== 1'b0 || o_stall !== 1'b0) begin bad++; $display("FAIL flush_outputs got v=%0b s=%0b exp v=0 s=0", o_valid, o_stall); end
        total++; if (o_drop_cnt !== 8'd0 || o_beat_cnt !== 8'd15) begin bad++; $display("FAIL flush_counts got drops=%0d beats=%0d exp drops=0 beats=15", o_drop_cnt, o_beat_cnt); end
        drive(1'b1, 16'h0020, 1'b0, 1'b0);
        step();
        total++; if (o_valid !== 1'b1 || o_data !== 16'h0021) begin bad++; $display("FAIL flush_resume got v=%0b d=%h exp v=1 d=0021", o_valid, o_data); end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        total++; if (o_beat_cnt !== 8'd16) begin bad++; $display("FAIL flush_beats got=%0d exp=16", o_beat_cnt); end
    endtask

    task automatic test_drop();
        drive(1'b1, 16'h0030, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0031, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0099, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        total++; if (o_drop_cnt !== 8'd4) begin bad++; $display("FAIL drop_four got=%0d exp=4", o_drop_cnt); end
        total++; if (o_data !== 16'h0031 || o_stall !== 1'b1) begin bad++; $display("FAIL drop_held got d=%h s=%0b exp d=0031 s=1", o_data, o_stall); end
        for (int i = 4; i < 300; i++) step();
        total++; if (o_drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_saturate got=%0d exp=255", o_drop_cnt); end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        total++; if (o_data !== 16'h0032 || o_stall !== 1'b0) begin bad++; $display("FAIL drop_skid_intact got d=%h s=%0b exp d=0032 s=0", o_data, o_stall); end
        step();
        total++; if (o_valid !== 1'b0 || o_beat_cnt !== 8'd18) begin bad++; $display("FAIL drop_drain got v=%0b beats=%0d exp v=0 beats=18", o_valid, o_beat_cnt); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 16'h0050, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0051, 1'b1, 1'b0);
        step();
        total++; if (o_stall !== 1'b1 || o_valid !== 1'b1) begin bad++; $display("FAIL areset_setup got s=%0b v=%0b exp s=1 v=1", o_stall, o_valid); end
        #2;
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_data !== 16'h0000 || o_drop_cnt !== 8'd0 || o_beat_cnt !== 8'd0) begin
            bad++;
            $display("FAIL areset_clear got v=%0b s=%0b d=%h drops=%0d beats=%0d exp all zero", o_valid, o_stall, o_data, o_drop_cnt, o_beat_cnt);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        drive(1'b1, 16'h0060, 1'b0, 1'b0);
        step();
        total++; if (o_valid !== 1'b1 || o_data !== 16'h0061) begin bad++; $display("FAIL areset_resume got v=%0b d=%h exp v=1 d=0061", o_valid, o_data); end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        total++; if (o_valid !== 1'b0 || o_beat_cnt !== 8'd1) begin bad++; $display("FAIL areset_beats got v=%0b beats=%0d exp v=0 beats=1", o_valid, o_beat_cnt); end
    endtask

    initial begin
        i_rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_wrap();
        test_stall();
        test_flush();
        test_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_4.md
# stage_4

Fourth stage of the valid/ready pipeline, directly downstream of stage_3. Takes stage_3's registered data/valid, adds 1 (mod 2^DATA_W), and presents the result to the next stage through a 2-entry skid buffer that honours a downstream stall. Returns a registered stall to stage_3 and keeps drop and throughput counters for bench visibility.

## Interface
- DATA_W, 16, data width; matches stage_3 output width.
- CNT_W, 8, width of o_drop_cnt and o_beat_cnt.

- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous flush; empties stage contents.
- i_data  in  DATA_W  data from stage_3 (o_data).
- i_valid  in  1  valid from stage_3 (o_valid).
- o_stall  out  1  to stage_3; high = this stage cannot accept a beat this cycle.
- i_stall  in  1  from next stage; high = next stage not taking o_data this cycle.
- o_data  out  DATA_W  processed data to next stage.
- o_valid  out  1  o_data valid.
- o_drop_cnt  out  CNT_W  count of beats lost because they arrived while o_stall=1; saturating.
- o_beat_cnt  out  CNT_W  count of beats delivered downstream; wraps.

## Operation
- Definitions: accept = i_valid && !o_stall && !i_flush; deliver = o_valid && !i_stall.
- Storage: output register (out_q, drives o_data) and skid register (skid_q), each holding i_data+1 truncated to DATA_W. Example: 16'hFFFF becomes 16'h0000.
- State machine, 2 bits, registered:
  - EMPTY: o_valid=0, o_stall=0. On accept: out_q<=i_data+1, go to ONE.
  - ONE: o_valid=1, o_stall=0.
    - accept && deliver: out_q reloads, stay in ONE.
    - accept && !deliver: skid_q<=i_data+1, go to TWO.
    - !accept && deliver: go to EMPTY.
    - Otherwise hold.
  - TWO: o_valid=1, o_stall=1. No accept is possible. On deliver: out_q<=skid_q, go to ONE. Otherwise hold.
- Beat order is preserved. No beat is duplicated. A beat is never lost while o_stall=0.
- Drop: a cycle with i_valid=1, o_stall=1 and i_flush=0 increments o_drop_cnt. The counter saturates at 2^CNT_W-1. The beat is discarded and state is unchanged. stage_3 has no hold path, so the sender must not present beats while o_stall=1; this counter detects violations.
- o_beat_cnt increments by 1 on every deliver cycle with i_flush=0, and wraps to 0.
- Flush:
  - Next state is EMPTY; o_valid and o_stall fall next cycle.
  - Any beat on i_data that cycle is discarded and not counted as a drop.
  - A deliver in the flush cycle is not counted.
  - Counters are otherwise unchanged.
  - out_q and skid_q hold their values.
  - Flush has priority over accept, deliver and drop.
- o_data holds its last value while o_valid=0. The bench must not check it then, except after reset.

## Timing
- Reset (async assert, sync release): state=EMPTY, o_valid=0, o_stall=0, o_data=0, skid_q=0, o_drop_cnt=0, o_beat_cnt=0.
- Reset asserted mid-operation clears everything immediately, with no clock needed.
- Latency: a beat accepted at edge N is on o_data with o_valid=1 after edge N.
- Throughput: 1 beat/cycle while i_stall=0.
- o_stall, o_valid and o_data are pure register outputs. There is no combinational path from i_stall or i_valid to any output.
- Stall reaction: i_stall rises at cycle N while in ONE and a beat is accepted at N. That beat goes to skid_q, and o_stall=1 from N+1. Exactly one extra beat is absorbed.
- Release: i_stall falls at cycle M in TWO. The skid beat moves to out_q at edge M, and o_stall=0 from M+1.
- Simultaneous flush and reset: reset wins.

## Test plan
- Reset, then a stream of i_data 0x0000..0x0009, i_valid=1, i_stall=0 -> o_data 0x0001..0x000A on consecutive cycles, 1-cycle latency, o_beat_cnt=10, o_stall never high.
- i_data=0xFFFF, single beat -> o_data=0x0000, o_valid=1 for one cycle.
- Stream 0x10,0x11,0x12,… with i_stall high for 3 cycles starting when 0x11 is in out_q -> 0x12 lands in skid_q, o_stall=1 next cycle, 0x13 held by sender. After release, 0x12 (o_data 0x13) is delivered, o_stall drops one cycle later, and order is intact with no drops.
- Force state TWO, then drive i_valid=1 for 4 cycles while o_stall=1 -> o_drop_cnt=4, stored beats unchanged. Repeat 300 times with CNT_W=8 -> o_drop_cnt saturates at 255.
- In state TWO, pulse i_flush together with i_valid=1 -> next cycle o_valid=0, o_stall=0, o_drop_cnt unchanged. A following beat 0x20 yields o_data 0x21 one cycle later.
- Assert i_rst_n=0 asynchronously mid-stream in TWO -> all outputs zero before the next clock edge. After release, normal flow resumes with the 1-cycle latency.
